// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: multiplier FSM states and sizes.
package calc_pkg;

  localparam int MUL_W     = 8;
  localparam int MUL_STEPS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/add8_unit.sv
// Purely combinational ripple adder with carry-out, shared by every shift-and-add step.
module add8_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per RUN cycle.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips RUN and goes straight to DONE.
module mul_seq_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  localparam int CNT_W = $clog2(MUL_STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

  mul_state_t state_reg, state_next;

  logic [WIDTH-1:0]   acc_reg, mplier_reg, mcand_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [WIDTH-1:0]   addend, sum;
  logic               carry;
  logic [2*WIDTH-1:0] shift_next;
  logic               bypass;

`ifdef MUL_ZERO_BYPASS_EN
  assign bypass = (a == '0) || (b == '0);
`else
  assign bypass = 1'b0;
`endif

  assign addend = mplier_reg[0] ? mcand_reg : '0;

  add8_unit #(.WIDTH(WIDTH)) u_add (
    .a    (acc_reg),
    .b    (addend),
    .sum  (sum),
    .cout (carry)
  );

  // The adder carry becomes the new acc MSB, so nothing is lost on 0xFF*0xFF.
  assign shift_next = {carry, sum, mplier_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = bypass ? DONE : RUN;
      RUN:     if (count_reg == LAST_STEP) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready = (state_reg == IDLE);
  assign busy  = (state_reg == RUN);
  assign done  = (state_reg == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      mplier_reg <= '0;
      mcand_reg  <= '0;
      count_reg  <= '0;
      product    <= '0;
      ovf        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
            count_reg  <= '0;
            if (bypass) begin
              product <= '0;
              ovf     <= 1'b0;
            end
          end
        end
        RUN: begin
          acc_reg    <= shift_next[2*WIDTH-1:WIDTH];
          mplier_reg <= shift_next[WIDTH-1:0];
          count_reg  <= count_reg + CNT_W'(1);
          // Product and ovf only ever change together, on the edge into DONE.
          if (count_reg == LAST_STEP) begin
            product <= shift_next;
            ovf     <= |shift_next[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: scoreboard of expected products and latencies.
module tb_mul_seq_ctrl;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           ready, busy, done, ovf;
  logic [2*W-1:0] product;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [15:0] prod;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_latency(input logic [7:0] x, input logic [7:0] y);
`ifdef MUL_ZERO_BYPASS_EN
    if (x == 8'h00 || y == 8'h00) return 1;
`endif
    return 9;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start cycle and record what the result must be.
  task automatic issue(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.prod = {8'h00, x} * {8'h00, y};
    e.ovf  = (e.prod[15:8] != 8'h00);
    e.lat  = exp_latency(x, y);
    sb.push_back(e);
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge.
  task automatic wait_done(output int cyc, output bit timed_out);
    cyc = 1;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({ready, busy, done, ovf, product} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      tests_failed++;
      $display("FAIL reset_state: got ready=%b busy=%b done=%b ovf=%b product=%h, want 1 0 0 0 0000",
               ready, busy, done, ovf, product);
    end
    rst_n = 1'b1;
    tick();
    $display("[TB] reset: ready=%b product=%h", ready, product);
  endtask

  task automatic test_op(input string name, input logic [7:0] x, input logic [7:0] y);
    int cyc;
    bit to;
    exp_t e;
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_ready: got %b, want 1", name, ready);
    end
    issue(x, y);
    wait_done(cyc, to);
    e = sb.pop_front();
    tests_run++;
    if (to || cyc != e.lat) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d (timeout=%0d), want %0d", name, cyc, to, e.lat);
    end
    tests_run++;
    if (product !== e.prod) begin
      tests_failed++;
      $display("FAIL %s_product: got %h, want %h", name, product, e.prod);
    end
    tests_run++;
    if (ovf !== e.ovf) begin
      tests_failed++;
      $display("FAIL %s_ovf: got %b, want %b", name, ovf, e.ovf);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || ready !== 1'b1 || product !== e.prod) begin
      tests_failed++;
      $display("FAIL %s_after_done: got done=%b ready=%b product=%h, want 0 1 %h",
               name, done, ready, product, e.prod);
    end
    $display("[TB] %s: %h * %h -> %h ovf=%b in %0d cycles", name, x, y, product, ovf, cyc);
  endtask

  task automatic test_ignore_start();
    int cyc;
    int n_done;
    exp_t e;
    cyc = 1;
    n_done = 0;
    issue(8'h12, 8'h34);
    repeat (2) begin tick(); cyc++; end
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    tick();
    cyc++;
    start = 1'b0;
    while (cyc < 30) begin
      a = W'($urandom);
      b = W'($urandom);
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          e = sb.pop_front();
          tests_run++;
          if (cyc != e.lat || product !== e.prod || ovf !== e.ovf) begin
            tests_failed++;
            $display("FAIL ignore_start_result: got cyc=%0d product=%h ovf=%b, want %0d %h %b",
                     cyc, product, ovf, e.lat, e.prod, e.ovf);
          end
        end
      end
      tick();
      cyc++;
    end
    tests_run++;
    if (n_done != 1) begin
      tests_failed++;
      $display("FAIL ignore_start_done_count: got %0d, want 1", n_done);
    end
    tests_run++;
    if (product !== 16'h03A8) begin
      tests_failed++;
      $display("FAIL ignore_start_held: got %h, want 03a8", product);
    end
    $display("[TB] ignore_start: 12 * 34 -> %h, %0d done pulses", product, n_done);
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit to;
    int seen_done;
    exp_t e;
    issue(8'h55, 8'h66);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    tests_run++;
    if ({ready, busy, done, ovf, product} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      tests_failed++;
      $display("FAIL reset_mid_async: got ready=%b busy=%b done=%b ovf=%b product=%h, want 1 0 0 0 0000",
               ready, busy, done, ovf, product);
    end
    seen_done = 0;
    repeat (3) begin
      tick();
      if (done) seen_done++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      tick();
      if (done) seen_done++;
    end
    tests_run++;
    if (seen_done != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_done: got %0d done cycles, want 0", seen_done);
    end
    issue(8'h03, 8'h05);
    wait_done(cyc, to);
    e = sb.pop_front();
    tests_run++;
    if (to || product !== e.prod || ovf !== e.ovf) begin
      tests_failed++;
      $display("FAIL reset_mid_recover: got product=%h ovf=%b timeout=%0d, want %h %b",
               product, ovf, to, e.prod, e.ovf);
    end
    tick();
    $display("[TB] reset_mid: recovered 03 * 05 -> %h", product);
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit to;
    int bad_hold;
    exp_t e;
    issue(8'h10, 8'h10);
    wait_done(cyc, to);
    e = sb.pop_front();
    tests_run++;
    if (to || product !== e.prod || ovf !== e.ovf) begin
      tests_failed++;
      $display("FAIL b2b_first: got product=%h ovf=%b timeout=%0d, want %h %b",
               product, ovf, to, e.prod, e.ovf);
    end
    tick();
    issue(8'h02, 8'h03);
    bad_hold = 0;
    cyc = 1;
    while (!done && cyc < 40) begin
      if (product !== 16'h0100 || ovf !== 1'b1) bad_hold++;
      tick();
      cyc++;
    end
    tests_run++;
    if (bad_hold != 0) begin
      tests_failed++;
      $display("FAIL b2b_hold: got %0d cycles with changed result, want 0", bad_hold);
    end
    e = sb.pop_front();
    tests_run++;
    if (!done || cyc != e.lat || product !== e.prod || ovf !== e.ovf) begin
      tests_failed++;
      $display("FAIL b2b_second: got done=%b cyc=%0d product=%h ovf=%b, want 1 %0d %h %b",
               done, cyc, product, ovf, e.lat, e.prod, e.ovf);
    end
    tick();
    $display("[TB] back_to_back: 10 * 10 then 02 * 03 -> %h", product);
  endtask

  initial begin
    test_reset();
    test_op("basic", 8'h0F, 8'h0F);
    test_op("carry", 8'hFF, 8'hFF);
    test_op("overflow", 8'h80, 8'h02);
    test_op("zero_a", 8'h00, 8'h37);
    test_op("zero_b", 8'hA5, 8'h00);
    test_op("mixed", 8'h9C, 8'h3B);
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
